// File: rtl/finv_iter.sv
// Multi-cycle binary32 reciprocal: table seed plus ITER Newton-Raphson steps on one shared multiplier.
// Optional macro FINV_ITER_RNE_EN selects round-to-nearest-even; otherwise the result is truncated.
//   state | meaning
//   IDLE  | waiting for an operand, in_ready high
//   SEED  | build m = 1.frac and y0 from the seed table
//   MUL_A | t = 2 - m*y
//   MUL_B | y = y*t, advance iteration count
//   ROUND | normalise/round y, resolve special operands
//   DONE  | hold result until out_ready
module finv_iter #(
  parameter int ITER      = 2,
  parameter int SEED_BITS = 8,
  parameter int FRAC_W    = 30
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] s,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        overflow,
  output logic        underflow
);

  localparam int W  = FRAC_W + 2;
  localparam int PW = 2 * W;
  localparam int SW = SEED_BITS + 2;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [W-1:0] TWO = {2'b10, {FRAC_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, SEED, MUL_A, MUL_B, ROUND, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   s_q, s_d;
  logic [W-1:0]  m_q, m_d;
  logic [W-1:0]  y_q, y_d;
  logic [W-1:0]  t_q, t_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   d_q, d_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  // y0 = round(2^(SEED_BITS+2) / (1 + (i+0.5)/2^SEED_BITS)), evaluated at elaboration
  logic [SW-1:0] seed_tab [2**SEED_BITS];
  for (genvar g = 0; g < 2**SEED_BITS; g++) begin : g_seed
    localparam longint unsigned NUM = 64'd1 << (2*SEED_BITS + 4);
    localparam longint unsigned DEN = (64'd1 << (SEED_BITS + 1)) + 64'(2*g + 1);
    assign seed_tab[g] = SW'((NUM / DEN + 64'd1) / 64'd2);
  end

  logic [SW-1:0] seed;
  assign seed = seed_tab[s_q[22 -: SEED_BITS]];

  logic [W-1:0]  op_b;
  logic [PW-1:0] prod;
  logic [W-1:0]  prod_sh;

  always_comb begin
    op_b    = (state_q == MUL_A) ? m_q : t_q;
    prod    = PW'(y_q) * PW'(op_b);
    prod_sh = W'(prod >> FRAC_W);
  end

  logic        sg;
  logic [7:0]  e;
  logic [22:0] fr;
  logic [22:0] frac2y;
  logic [23:0] mant;
  logic [7:0]  exp_n;
  logic [31:0] res;
  logic        res_ovf;
  logic        res_udf;
`ifdef FINV_ITER_RNE_EN
  logic        guard;
  logic        sticky;
`endif

  always_comb begin
    sg     = s_q[31];
    e      = s_q[30:23];
    fr     = s_q[22:0];
    frac2y = y_q[FRAC_W-2 -: 23];
`ifdef FINV_ITER_RNE_EN
    guard  = y_q[FRAC_W-25];
    sticky = |y_q[FRAC_W-26:0];
    mant   = {1'b0, frac2y} + 24'(guard & (sticky | frac2y[0]));
`else
    mant   = {1'b0, frac2y};
`endif
    // a carry out of the fraction means 2y rounded to 2.0: bump exponent, fraction already zero
    exp_n   = 8'd253 - e + {7'd0, mant[23]};
    res     = {sg, exp_n, mant[22:0]};
    res_ovf = 1'b0;
    res_udf = 1'b0;
    if (e == 8'd0) begin
      res     = {sg, 8'hFF, 23'd0};
      res_ovf = 1'b1;
    end else if (e == 8'hFF) begin
      res = (fr == 23'd0) ? {sg, 31'd0} : 32'h7FC0_0000;
    end else if ((e >= 8'd254) || ((e == 8'd253) && (fr != 23'd0))) begin
      res     = {sg, 31'd0};
      res_udf = 1'b1;
    end else if (fr == 23'd0) begin
      res = {sg, 8'd254 - e, 23'd0};
    end
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    m_d         = m_q;
    y_d         = y_q;
    t_d         = t_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    d_d         = d_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          s_d        = s;
          in_ready_d = 1'b0;
          state_d    = SEED;
        end
      end
      SEED: begin
        m_d     = {2'b01, s_q[22:0], {(FRAC_W-23){1'b0}}};
        y_d     = W'(seed) << (FRAC_W - SW);
        cnt_d   = '0;
        state_d = MUL_A;
      end
      MUL_A: begin
        t_d     = TWO - prod_sh;
        state_d = MUL_B;
      end
      MUL_B: begin
        y_d   = prod_sh;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(ITER - 1)) ? ROUND : MUL_A;
      end
      ROUND: begin
        d_d         = res;
        ovf_d       = res_ovf;
        udf_d       = res_udf;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      s_q         <= '0;
      m_q         <= '0;
      y_q         <= '0;
      t_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      m_q         <= m_d;
      y_q         <= y_d;
      t_q         <= t_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_finv_iter.sv
// Directed bench for finv_iter: hand-computed reciprocals, specials, stall and mid-operation reset.
module tb_finv_iter;

  localparam int ITER_TB = 2;
  localparam int LAT     = 2 * ITER_TB + 3;

`ifdef FINV_ITER_RNE_EN
  localparam logic [31:0] E_M3  = 32'hBEAA_AAAB;
  localparam logic [31:0] E_5   = 32'h3E4C_CCCD;
  localparam logic [31:0] E_M5  = 32'hBE4C_CCCD;
  localparam logic [31:0] E_7   = 32'h3E12_4925;
  localparam logic [31:0] E_075 = 32'h3FAA_AAAB;
`else
  localparam logic [31:0] E_M3  = 32'hBEAA_AAAA;
  localparam logic [31:0] E_5   = 32'h3E4C_CCCC;
  localparam logic [31:0] E_M5  = 32'hBE4C_CCCC;
  localparam logic [31:0] E_7   = 32'h3E12_4924;
  localparam logic [31:0] E_075 = 32'h3FAA_AAAA;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] s = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] d;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  finv_iter #(.ITER(ITER_TB), .SEED_BITS(8), .FRAC_W(30)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // present x for one edge, then count edges until out_valid (bounded)
  task automatic issue(input logic [31:0] x, output int lat);
    @(negedge clk);
    s = x;
    in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 40);
  endtask

  task automatic do_vec(input string tag, input logic [31:0] x, input logic [31:0] exp_d,
                        input logic ov, input logic un);
    int lat;
    out_ready = 1'b1;
    issue(x, lat);
    check({tag, " lat"}, lat, LAT);
    check({tag, " d"}, d, exp_d);
    check({tag, " ovf"}, {31'd0, overflow}, {31'd0, ov});
    check({tag, " udf"}, {31'd0, underflow}, {31'd0, un});
    @(posedge clk);
    #1;
    check({tag, " release"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst outs", {28'd0, in_ready, out_valid, overflow, underflow}, 32'h8);
    check("rst d", d, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    do_vec("two",     32'h4000_0000, 32'h3F00_0000, 1'b0, 1'b0);
    do_vec("one",     32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
    do_vec("neg3",    32'hC040_0000, E_M3,          1'b0, 1'b0);
    do_vec("five",    32'h40A0_0000, E_5,           1'b0, 1'b0);
    do_vec("seven",   32'h40E0_0000, E_7,           1'b0, 1'b0);
    do_vec("p75",     32'h3F40_0000, E_075,         1'b0, 1'b0);
    do_vec("zero",    32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b0);
    do_vec("ndenorm", 32'h8000_0001, 32'hFF80_0000, 1'b1, 1'b0);
    do_vec("ninf",    32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b0);
    do_vec("nan",     32'h7FC0_0001, 32'h7FC0_0000, 1'b0, 1'b0);
    do_vec("e254",    32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b1);
    do_vec("e253",    32'h7E80_0000, 32'h0080_0000, 1'b0, 1'b0);
    do_vec("e253f",   32'h7E90_0000, 32'h0000_0000, 1'b0, 1'b1);
    do_vec("ne253",   32'hFE80_0000, 32'h8080_0000, 1'b0, 1'b0);

    // stall in DONE with a stray operand offered meanwhile
    out_ready = 1'b0;
    issue(32'hC0A0_0000, lat);
    check("stall lat", lat, LAT);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) begin
        s = 32'h3F80_0000;
        in_valid = 1'b1;
      end
      if (i == 5) in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("stall d", d, E_M5);
      check("stall hs", {29'd0, out_valid, in_ready, overflow | underflow}, 32'h4);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall release", {30'd0, out_valid, in_ready}, 32'd1);
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) seen++;
    end
    check("stray not captured", seen, 0);

    // reset while in MUL_A
    @(negedge clk);
    s = 32'h4040_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("abort outs", {28'd0, in_ready, out_valid, overflow, underflow}, 32'h8);
    check("abort d", d, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort no result", seen, 0);
    do_vec("four", 32'h4080_0000, 32'h3E80_0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/finv_iter.md
# finv_iter

Multi-cycle, parametrised IEEE-754 single-precision reciprocal unit (1/x) for the FPU.
- Computes a seed from a lookup table, then runs ITER Newton–Raphson steps, y ← y·(2 − m·y), on one shared multiplier.
- Handles special operands and drives the overflow/underflow flags.
- Sits behind the FPU issue logic with valid/ready handshakes on both sides; a successor to the single-cycle combinational reciprocal.

## Interface
Parameters:
- ITER, 2, Newton iterations (1..4).
- SEED_BITS, 8, mantissa MSBs indexing the seed table (4..10).
- FRAC_W, 30, fractional bits of the internal fixed-point datapath (≥ 26).

Ports:
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  operand valid.
- in_ready  out  1  unit can accept an operand.
- s  in  32  operand (binary32).
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- d  out  32  result (binary32).
- overflow  out  1  result saturated to ±inf (zero/denormal operand); qualified by out_valid.
- underflow  out  1  result flushed to ±0 from a finite nonzero operand; qualified by out_valid.

## Operation
- FSM states: IDLE → SEED → MUL_A → MUL_B (repeat ITER times) → ROUND → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - in_valid && in_ready latches s and goes to SEED.
- SEED:
  - m = 1.frac as Q2.FRAC_W.
  - y0 = 1/(1+(i+0.5)/2^SEED_BITS), rounded to SEED_BITS+2 bits and zero-extended, with i = frac[22:23−SEED_BITS].
  - Iteration counter is cleared.
- MUL_A: t = 2 − (m·y), truncated to Q2.FRAC_W.
- MUL_B:
  - y = y·t, truncated to Q2.FRAC_W.
  - Counter increments; go to ROUND when counter == ITER−1, else back to MUL_A.
- ROUND (m == 1.0 exactly, i.e. frac == 0):
  - result mantissa = 0.
  - exponent = 254 − e.
- ROUND (otherwise):
  - y lies in (0.5,1); normalise 2y.
  - exponent = 253 − e.
  - Round 2y to 23 fraction bits (see Configuration).
  - A rounding carry to 2.0 increments the exponent and clears the fraction.
- Special cases are decided from the latched s in ROUND, with the same latency as normal operands:
  - e == 0 (zero or denormal; denormals flush): d = {sign, 8'hFF, 0}, overflow=1.
  - e == 255, frac == 0: d = {sign, 31'b0}, both flags 0.
  - e == 255, frac != 0: d = 32'h7FC00000, both flags 0.
  - Computed exponent ≤ 0 (e ≥ 254, or e == 253 with frac ≠ 0): d = {sign, 31'b0}, underflow=1.
- Sign of d always equals the sign of s, except NaN.
- DONE: out_valid=1; d and the flags are held stable until out_ready; then go to IDLE.
- Accuracy (ITER=2, SEED_BITS=8, RNE on): within 1 ulp of the correctly rounded result for every normal operand.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, d=0, overflow=0, underflow=0; latched operand and y cleared.
- Latency: 2·ITER+3 cycles from the accept edge to out_valid=1 (7 for ITER=2).
- in_ready=0 from the accept edge until the edge after the output handshake. No operand overlap.
- Throughput: one result per 2·ITER+4 cycles when out_ready stays high.
- out_ready held low stalls indefinitely in DONE; d and flags stay constant.
- in_valid while in_ready=0 is ignored; the operand is not captured.
- rstn asserted mid-operation aborts at once to reset values; no result is emitted for the aborted operand.

## Configuration
- FINV_ITER_RNE_EN defined:
  - ROUND does round-to-nearest-even using guard, round and sticky (OR of all lower bits of 2y).
  - Mantissa carry handled as above.
- FINV_ITER_RNE_EN undefined:
  - Result fraction is 2y truncated (round toward zero); no carry path.
  - Error bound becomes < 2 ulp.

## Test plan
- s=32'h40000000 (2.0) -> d=32'h3F000000, flags 0, out_valid exactly 7 cycles after accept (ITER=2).
- s=32'h3F800000 (1.0) -> d=32'h3F800000; s=32'hC0400000 (−3.0) -> d=32'hBEAAAAAB with RNE (32'hBEAAAAAA without).
- s=32'h00000000 -> d=32'h7F800000, overflow=1; s=32'hFF800000 -> d=32'h80000000; s=32'h7FC00001 -> d=32'h7FC00000.
- s=32'h7F000000 (2^127) -> d=32'h00000000, underflow=1; s=32'h7E800000 (2^126) -> d=32'h00800000, flags 0.
- out_ready low 10 cycles after out_valid -> d stable, in_ready=0 throughout; a second in_valid during the stall is not captured.
- rstn pulsed low during MUL_A -> all outputs at reset values; next operand 32'h40800000 (4.0) -> d=32'h3E800000.
